// File: rtl/ripple_carry_adder_4bit_pkg.sv
// rtl/ripple_carry_adder_4bit_pkg.sv - shared constants for the registered ripple-carry adder
//
// Purpose : Holds the default operand width used by the adder top and
//           anything that instantiates it.
// Contents: ADDER_WIDTH - default operand/sum width (4).
package ripple_carry_adder_4bit_pkg;

    localparam int ADDER_WIDTH = 4;

endpackage : ripple_carry_adder_4bit_pkg

// File: rtl/ripple_carry_adder_4bit_full_adder.sv
// rtl/ripple_carry_adder_4bit_full_adder.sv - 1-bit combinational full adder cell
//
// Purpose : One stage of the ripple chain. Purely combinational.
// Ports   : a, b - operand bits
//           ci   - carry in from the previous stage
//           s    - sum bit
//           co   - carry out to the next stage
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    // Propagate term is shared by the sum and the carry.
    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder_4bit.sv
// rtl/ripple_carry_adder_4bit.sv - registered ripple-carry adder, {Cout,Sum} = A + B + Cin
//
// Purpose : WIDTH-bit unsigned adder built from a chain of full_adder cells,
//           followed by one output register stage (latency 1, throughput 1).
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset; clears Sum and Cout
//           A, B  - unsigned addends [WIDTH-1:0]
//           Cin   - carry into bit 0
//           Sum   - registered sum [WIDTH-1:0]
//           Cout  - registered carry out of the top bit
module ripple_carry_adder_4bit
    import ripple_carry_adder_4bit_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // c[i] is the carry into bit i; c[WIDTH] leaves the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum_d[i]),
            .co (carry[i+1])
        );
    end : g_chain

    assign cout_d = carry[WIDTH];

    // Reset wins over the add, so an in-flight result is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;

endmodule : ripple_carry_adder_4bit

// File: tb/tb_ripple_carry_adder_4bit.sv
// tb/tb_ripple_carry_adder_4bit.sv - self-checking bench for ripple_carry_adder_4bit
module tb_ripple_carry_adder_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;

    int tests;
    int fails;

    typedef struct {
        logic       rst_n;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[14];

    ripple_carry_adder_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .Sum   (sum),
        .Cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {Cout,Sum}=%b_%h, expected %b_%h",
                     name, act[4], act[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Drive one operand set, let one edge sample it, then check 1ns later.
    task automatic step(input string name, input logic r, input logic [3:0] va,
                        input logic [3:0] vb, input logic vc, input logic [4:0] exp);
        rst_n = r;
        a     = va;
        b     = vb;
        cin   = vc;
        @(posedge clk);
        #1;
        check(name, {cout, sum}, exp);
    endtask

    // Reference: plain unsigned arithmetic, or zero while reset is asserted.
    function automatic logic [4:0] model(input logic r, input logic [3:0] va,
                                         input logic [3:0] vb, input logic vc);
        int total;
        total = int'(va) + int'(vb) + int'(vc);
        return r ? 5'(total) : 5'd0;
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a     = 4'hF;
        b     = 4'hF;
        cin   = 1'b1;

        vecs[0]  = '{1'b0, 4'hF, 4'hF, 1'b1, 5'h00};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 1'b1, 5'h00};
        vecs[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 5'h1F};
        vecs[3]  = '{1'b1, 4'h0, 4'h0, 1'b0, 5'h00};
        vecs[4]  = '{1'b1, 4'h1, 4'h2, 1'b0, 5'h03};
        vecs[5]  = '{1'b1, 4'h5, 4'h6, 1'b0, 5'h0B};
        vecs[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 5'h1F};
        vecs[7]  = '{1'b1, 4'hA, 4'h5, 1'b1, 5'h10};
        vecs[8]  = '{1'b1, 4'hF, 4'h0, 1'b1, 5'h10};
        vecs[9]  = '{1'b1, 4'h7, 4'h8, 1'b0, 5'h0F};
        vecs[10] = '{1'b1, 4'h8, 4'h8, 1'b0, 5'h10};
        vecs[11] = '{1'b1, 4'h0, 4'h0, 1'b1, 5'h01};
        vecs[12] = '{1'b0, 4'h9, 4'h9, 1'b1, 5'h00};
        vecs[13] = '{1'b1, 4'h3, 4'hC, 1'b1, 5'h10};

        for (int i = 0; i < 14; i++) begin
            step($sformatf("table[%0d]", i), vecs[i].rst_n, vecs[i].a, vecs[i].b,
                 vecs[i].cin, vecs[i].exp);
        end

        // Output holds between edges even when inputs change.
        step("hold_load", 1'b1, 4'h6, 4'h3, 1'b0, 5'h09);
        a   = 4'hF;
        b   = 4'hF;
        cin = 1'b1;
        #3;
        check("hold_no_comb_path", {cout, sum}, 5'h09);
        @(posedge clk);
        #1;
        check("hold_next_edge", {cout, sum}, 5'h1F);

        // Back-to-back stream of all 512 combinations, reset pulsed once mid-stream.
        for (int k = 0; k < 512; k++) begin
            logic       r;
            logic [3:0] va;
            logic [3:0] vb;
            logic       vc;
            va = 4'(k >> 5);
            vb = 4'(k >> 1);
            vc = k[0];
            r  = (k != 300);
            step($sformatf("stream[%0d]", k), r, va, vb, vc, model(r, va, vb, vc));
        end

        // Randomized operands with occasional reset.
        for (int k = 0; k < 300; k++) begin
            logic       r;
            logic [3:0] va;
            logic [3:0] vb;
            logic       vc;
            va = 4'($urandom_range(15, 0));
            vb = 4'($urandom_range(15, 0));
            vc = 1'($urandom_range(1, 0));
            r  = ($urandom_range(19, 0) != 0);
            step($sformatf("rand[%0d]", k), r, va, vb, vc, model(r, va, vb, vc));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ripple_carry_adder_4bit
